// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: moves a single lit LED on each player's press, detects
// round wins at either end and keeps saturating per-player round scores.
module tug_of_war_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_press,
  input  logic                  r_press,
  input  logic                  next_round,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    l_score,
  output logic [SCORE_W-1:0]    r_score,
  output logic                  game_over
);

  localparam int PW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam logic [PW-1:0]      CENTRE = PW'(NUM_LIGHTS / 2);
  localparam logic [PW-1:0]      LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] MAX    = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {PLAY, WON, GAME_OVER} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       pos, pos_n;
  logic [1:0]          winner_n;
  logic [SCORE_W-1:0]  l_score_n, r_score_n;
  logic                mv_l, mv_r;

  // Simultaneous presses cancel each other.
  assign mv_l = l_press & ~r_press;
  assign mv_r = r_press & ~l_press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PLAY;
      pos     <= CENTRE;
      winner  <= 2'b00;
      l_score <= '0;
      r_score <= '0;
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      winner  <= winner_n;
      l_score <= l_score_n;
      r_score <= r_score_n;
    end
  end

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    winner_n  = winner;
    l_score_n = l_score;
    r_score_n = r_score;
    case (state)
      PLAY: begin
        if (mv_l) begin
          if (pos == LAST) begin
            winner_n  = 2'b01;
            l_score_n = l_score + SCORE_W'(1);
            state_n   = (l_score_n == MAX) ? GAME_OVER : WON;
          end else begin
            pos_n = pos + PW'(1);
          end
        end else if (mv_r) begin
          if (pos == '0) begin
            winner_n  = 2'b10;
            r_score_n = r_score + SCORE_W'(1);
            state_n   = (r_score_n == MAX) ? GAME_OVER : WON;
          end else begin
            pos_n = pos - PW'(1);
          end
        end
      end
      WON: begin
        if (next_round) begin
          state_n  = PLAY;
          pos_n    = CENTRE;
          winner_n = 2'b00;
        end
      end
      default: ;
    endcase
  end

  // The row is dark whenever a round is not in play.
  assign leds      = (state == PLAY) ? (NUM_LIGHTS'(1) << pos) : '0;
  assign game_over = (state == GAME_OVER);

endmodule

// File: doc/tug_of_war_field.md
# tug_of_war_field

Playfield controller for the tug-of-war game. It sits directly downstream of the two per-player button input stages and consumes their one-cycle press pulses. It moves a single lit position along a row of LEDs, detects a round win when the light is pushed past either end, and keeps per-player round scores. When a player's score saturates, the game is over.

## Interface
Parameters:
- NUM_LIGHTS, 9, number of playfield LEDs; must be odd and ≥ 3; centre index C = NUM_LIGHTS/2 (integer division)
- SCORE_W, 3, width of each score counter; the maximum score is MAX = 2^SCORE_W − 1

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; 0 resets immediately, with no dependence on clk
- l_press  in  1  one-cycle press pulse from the left player's input stage
- r_press  in  1  one-cycle press pulse from the right player's input stage
- next_round  in  1  one-cycle pulse that starts a new round after a win
- leds  out  NUM_LIGHTS  one-hot playfield; bit 0 is the rightmost LED, bit NUM_LIGHTS−1 is the leftmost LED
- winner  out  2  round winner: 00 none, 01 left, 10 right; 11 is never driven
- l_score  out  SCORE_W  left player's rounds won
- r_score  out  SCORE_W  right player's rounds won
- game_over  out  1  high while in the GAME_OVER state

## Operation
- State registers:
  - pos, range 0..NUM_LIGHTS−1
  - FSM state: PLAY, WON, or GAME_OVER
  - winner register
  - two score counters
- All outputs are registered or decoded directly from registers. There is no combinational path from inputs to outputs.
- Reset values (reset = 0):
  - state = PLAY, pos = C
  - leds = one-hot at bit C
  - winner = 00
  - l_score = 0, r_score = 0
  - game_over = 0
- Input decode, evaluated each cycle:
  - mv_l = l_press & ~r_press
  - mv_r = r_press & ~l_press
  - If both presses arrive in the same cycle, they cancel and nothing happens.
- PLAY:
  - mv_l with pos < NUM_LIGHTS−1: pos ← pos+1.
  - mv_l with pos = NUM_LIGHTS−1: the left player wins the round.
    - winner ← 01; l_score ← l_score+1.
    - If the new l_score equals MAX, go to GAME_OVER; otherwise go to WON.
    - pos is unchanged.
  - mv_r mirrors mv_l: pos ← pos−1, or a right win at pos = 0 (winner ← 10, r_score increments).
  - next_round is ignored in PLAY.
- WON:
  - leds = all zero; winner and scores are held.
  - l_press and r_press are ignored.
  - next_round: state ← PLAY, pos ← C, winner ← 00. Scores are kept.
- GAME_OVER:
  - leds = all zero; winner is held; game_over = 1.
  - All inputs are ignored. Only reset leaves this state.
- leds decode: one-hot at pos in PLAY, zero in WON and GAME_OVER.
- Scores never wrap. An increment happens only on a win transition, and GAME_OVER blocks any further win, so a score cannot exceed MAX.
- Exactly one score increments per win. The losing player's score is never modified.

## Timing
- Press pulse sampled at edge N: leds and pos reflect the move after edge N, i.e. one cycle of latency.
- Winning press at edge N: after edge N the following are all valid together:
  - state = WON or GAME_OVER
  - winner set
  - score incremented
  - leds = 0
- next_round at edge N while in WON: leds is one-hot at C and winner = 00 after edge N.
- A press in the same cycle as next_round in WON is ignored. The first move in the new round comes from a press at edge N+1 or later.
- Back-to-back presses (one every cycle) each move one position; no press is dropped or merged.
- Reset asserted mid-round or mid-WON: all outputs take their reset values asynchronously, before the next clk edge, and scores clear.
- Reset deasserted: the first state update happens at the first rising clk edge with reset = 1.

## Test plan
- Reset, then 4 single-cycle l_press pulses spaced 2 cycles apart → leds steps 0x010 → 0x020 → 0x040 → 0x080 → 0x100, one cycle after each pulse; winner stays 00.
- From centre, l_press and r_press high together for 3 cycles → leds stays 0x010 and the scores are unchanged; then 5 r_press pulses → after the 5th pulse, leds = 0, winner = 10, r_score = 1, and extra presses have no effect.
- In WON, next_round together with l_press → next cycle leds = 0x010 and winner = 00; the l_press is ignored.
- Seven left-win rounds with SCORE_W = 3 → after the 7th win, l_score = 7 and game_over = 1; a further next_round and presses leave all outputs unchanged.
- Drop reset to 0 asynchronously mid-round with pos = 2 and l_score = 3 → leds = 0x010 and l_score = 0 before the next clk edge; normal play resumes after release.
- Parameter sweep NUM_LIGHTS = 3 and SCORE_W = 1 → one r_press from reset reaches pos 0, a second r_press wins the round and goes straight to GAME_OVER with r_score = 1.
